ps2_host_tx: RTL and testbench

PS2_HOST_TX -- requirements
Module: ps2_host_tx

---
 rtl/ps2_host_tx.sv | 184 ++++++++++++++++++
 tb/tb_ps2_host_tx.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibits the bus, issues a request-to-send, then shifts
// one command byte (LSB first, odd parity, stop) on device clock edges and checks the ack.
module ps2_host_tx #(
    parameter int unsigned INHIBIT_CYCLES = 6000,
    parameter int unsigned TIMEOUT_CYCLES = 750000
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic [7:0] i_data,
    input  logic       i_start,
    input  logic       i_ps2_clk,
    input  logic       i_ps2_dat,
    output logic       o_ps2_clk_oe,
    output logic       o_ps2_dat_oe,
    output logic       o_busy,
    output logic       o_done,
    output logic       o_ack_err,
    output logic       o_timeout
);

    typedef enum logic [2:0] {
        StIdle,
        StInhibit,
        StReq,
        StSend,
        StAck,
        StWaitIdle,
        StDone
    } state_e;

    state_e      state_q, state_d;
    logic        clk_meta_q, clk_sync_q, clk_prev_q;
    logic        dat_meta_q, dat_sync_q;
    logic [7:0]  data_q, data_d;
    logic        parity_q, parity_d;
    logic [3:0]  bit_idx_q, bit_idx_d;
    logic [31:0] cnt_q, cnt_d;
    logic        dat_oe_q, dat_oe_d;
    logic        ack_err_q, ack_err_d;
    logic        timeout_q, timeout_d;

    logic        fe;
    logic [31:0] cnt_next;
    logic        timed_out;

    assign fe        = clk_prev_q & ~clk_sync_q;
    assign cnt_next  = cnt_q + 32'd1;
    // Fires on the cycle the gap since the last edge would reach the limit.
    assign timed_out = (cnt_next == TIMEOUT_CYCLES);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q    <= StIdle;
            clk_meta_q <= 1'b1;
            clk_sync_q <= 1'b1;
            clk_prev_q <= 1'b1;
            dat_meta_q <= 1'b1;
            dat_sync_q <= 1'b1;
            data_q     <= 8'h00;
            parity_q   <= 1'b0;
            bit_idx_q  <= 4'd0;
            cnt_q      <= 32'd0;
            dat_oe_q   <= 1'b0;
            ack_err_q  <= 1'b0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            clk_meta_q <= i_ps2_clk;
            clk_sync_q <= clk_meta_q;
            clk_prev_q <= clk_sync_q;
            dat_meta_q <= i_ps2_dat;
            dat_sync_q <= dat_meta_q;
            data_q     <= data_d;
            parity_q   <= parity_d;
            bit_idx_q  <= bit_idx_d;
            cnt_q      <= cnt_d;
            dat_oe_q   <= dat_oe_d;
            ack_err_q  <= ack_err_d;
            timeout_q  <= timeout_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        data_d    = data_q;
        parity_d  = parity_q;
        bit_idx_d = bit_idx_q;
        cnt_d     = cnt_q;
        dat_oe_d  = dat_oe_q;
        ack_err_d = ack_err_q;
        timeout_d = timeout_q;

        case (state_q)
            StIdle: begin
                dat_oe_d = 1'b0;
                cnt_d    = 32'd0;
                if (i_start) begin
                    data_d    = i_data;
                    parity_d  = ~^i_data;
                    ack_err_d = 1'b0;
                    timeout_d = 1'b0;
                    state_d   = StInhibit;
                end
            end
            StInhibit: begin
                if (cnt_q == INHIBIT_CYCLES - 32'd1) begin
                    cnt_d    = 32'd0;
                    dat_oe_d = 1'b1;
                    state_d  = StReq;
                end else begin
                    cnt_d = cnt_next;
                end
            end
            StReq: begin
                cnt_d     = 32'd0;
                bit_idx_d = 4'd0;
                state_d   = StSend;
            end
            StSend: begin
                if (fe) begin
                    cnt_d     = 32'd0;
                    bit_idx_d = bit_idx_q + 4'd1;
                    if (bit_idx_q < 4'd8) begin
                        dat_oe_d = ~data_q[bit_idx_q[2:0]];
                    end else if (bit_idx_q == 4'd8) begin
                        dat_oe_d = ~parity_q;
                    end else begin
                        dat_oe_d = 1'b0;
                        state_d  = StAck;
                    end
                end else if (timed_out) begin
                    cnt_d     = 32'd0;
                    dat_oe_d  = 1'b0;
                    timeout_d = 1'b1;
                    state_d   = StDone;
                end else begin
                    cnt_d = cnt_next;
                end
            end
            StAck: begin
                if (fe) begin
                    cnt_d     = 32'd0;
                    ack_err_d = dat_sync_q;
                    state_d   = StWaitIdle;
                end else if (timed_out) begin
                    cnt_d     = 32'd0;
                    dat_oe_d  = 1'b0;
                    timeout_d = 1'b1;
                    state_d   = StDone;
                end else begin
                    cnt_d = cnt_next;
                end
            end
            StWaitIdle: begin
                if (clk_sync_q && dat_sync_q) begin
                    cnt_d   = 32'd0;
                    state_d = StDone;
                end else if (fe) begin
                    cnt_d = 32'd0;
                end else if (timed_out) begin
                    cnt_d     = 32'd0;
                    dat_oe_d  = 1'b0;
                    timeout_d = 1'b1;
                    state_d   = StDone;
                end else begin
                    cnt_d = cnt_next;
                end
            end
            StDone: begin
                cnt_d   = 32'd0;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    assign o_ps2_clk_oe = (state_q == StInhibit) || (state_q == StReq);
    assign o_ps2_dat_oe = dat_oe_q;
    assign o_busy       = (state_q != StIdle);
    assign o_done       = (state_q == StDone);
    assign o_ack_err    = ack_err_q;
    assign o_timeout    = timeout_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: a PS/2 device model clocks frames out of the host and the sampled
// bits are compared against a frame built directly from the byte's value.
module tb_ps2_host_tx;

    localparam int unsigned INH = 20;
    localparam int unsigned TMO = 200;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] data;
    logic       start;
    logic       dev_clk_low;
    logic       dev_dat_low;
    logic       ps2_clk;
    logic       ps2_dat;
    logic       ps2_clk_oe;
    logic       ps2_dat_oe;
    logic       busy;
    logic       done;
    logic       ack_err;
    logic       timeout;

    int n_checks = 0;
    int n_fail   = 0;
    int done_cnt = 0;
    int half     = 10;

    // Open-collector bus: either side may pull a line low.
    assign ps2_clk = ~(ps2_clk_oe | dev_clk_low);
    assign ps2_dat = ~(ps2_dat_oe | dev_dat_low);

    always #5 clk = ~clk;

    ps2_host_tx #(
        .INHIBIT_CYCLES(INH),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_data      (data),
        .i_start     (start),
        .i_ps2_clk   (ps2_clk),
        .i_ps2_dat   (ps2_dat),
        .o_ps2_clk_oe(ps2_clk_oe),
        .o_ps2_dat_oe(ps2_dat_oe),
        .o_busy      (busy),
        .o_done      (done),
        .o_ack_err   (ack_err),
        .o_timeout   (timeout)
    );

    always @(negedge clk) if (done) done_cnt <= done_cnt + 1;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Frame as the device should see it on its rising edges: d0..d7, odd parity, stop.
    function automatic logic [9:0] model_frame(input logic [7:0] d);
        logic [9:0] f;
        int ones;
        ones = 0;
        for (int i = 0; i < 8; i++) begin
            f[i] = d[i];
            ones += int'(d[i]);
        end
        f[8] = ((ones % 2) == 0);
        f[9] = 1'b1;
        return f;
    endfunction

    // Issue a request and follow the host through inhibit and request; ends on the first
    // SEND cycle.
    task automatic start_and_req(input logic [7:0] d);
        int n;
        int guard;
        @(negedge clk);
        data  = d;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check_eq("latency_clk_oe", 32'(ps2_clk_oe), 32'd1);
        check_eq("inhibit_busy", 32'(busy), 32'd1);
        n = 0;
        guard = 0;
        while (ps2_clk_oe && !ps2_dat_oe && guard < 1000) begin
            n++;
            guard++;
            @(negedge clk);
        end
        check_eq("inhibit_len", 32'(n), 32'(INH));
        check_eq("req_oes", {30'd0, ps2_clk_oe, ps2_dat_oe}, 32'd3);
        @(negedge clk);
        check_eq("send_oes", {30'd0, ps2_clk_oe, ps2_dat_oe}, 32'd1);
    endtask

    // Device side: n_fe > 0 stops with the clock held low after that many falling edges.
    task automatic dev_frame(input int n_fe, input bit ack, output logic [9:0] bits);
        bits = '0;
        repeat (4) @(negedge clk);
        for (int i = 1; i <= 11; i++) begin
            if (i == 11 && ack) begin
                dev_dat_low = 1'b1;
                repeat (3) @(negedge clk);
            end
            dev_clk_low = 1'b1;
            if (i == n_fe) return;
            repeat (half) @(negedge clk);
            if (i == 11) begin
                dev_clk_low = 1'b0;
                dev_dat_low = 1'b0;
                return;
            end
            dev_clk_low = 1'b0;
            bits[i-1] = ps2_dat;
            repeat (half) @(negedge clk);
        end
    endtask

    task automatic do_send(input logic [7:0] d, input bit ack, input bit inject);
        logic [9:0] bits;
        int n;
        start_and_req(d);
        fork
            dev_frame(0, ack, bits);
            if (inject) begin
                repeat (50) @(negedge clk);
                data  = 8'h55;
                start = 1'b1;
                @(negedge clk);
                start = 1'b0;
            end
        join
        check_eq("frame_bits", 32'(bits), 32'(model_frame(d)));
        n = 0;
        while (!done && n < 100) begin
            @(negedge clk);
            n++;
        end
        check_eq("done_seen", 32'(done), 32'd1);
        check_eq("ack_err", 32'(ack_err), 32'(!ack));
        check_eq("no_timeout", 32'(timeout), 32'd0);
        @(negedge clk);
        check_eq("done_pulse_idle", {30'd0, done, busy}, 32'd0);
        check_eq("ack_err_held", 32'(ack_err), 32'(!ack));
    endtask

    initial begin
        logic [9:0] bits;
        int n;
        int dc;
        rst         = 1'b1;
        start       = 1'b0;
        data        = 8'h00;
        dev_clk_low = 1'b0;
        dev_dat_low = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check_eq("reset_outputs",
                 {26'd0, ps2_clk_oe, ps2_dat_oe, busy, done, ack_err, timeout}, 32'd0);

        do_send(8'hED, 1'b1, 1'b0);
        do_send(8'h01, 1'b1, 1'b0);
        do_send(8'hFF, 1'b1, 1'b0);
        do_send(8'hA5, 1'b0, 1'b0);
        do_send(8'hED, 1'b1, 1'b1);

        // Device never clocks after the request.
        start_and_req(8'h3C);
        n = 0;
        while (!done && n < 400) begin
            @(negedge clk);
            n++;
        end
        check_eq("timeout_latency", 32'(n), 32'(TMO));
        check_eq("timeout_flag", 32'(timeout), 32'd1);
        check_eq("timeout_oes", {30'd0, ps2_clk_oe, ps2_dat_oe}, 32'd0);
        @(negedge clk);
        check_eq("timeout_held", {30'd0, timeout, busy}, 32'd2);

        // Reset after the fifth falling edge.
        start_and_req(8'hA7);
        dev_frame(5, 1'b0, bits);
        repeat (4) @(negedge clk);
        check_eq("busy_before_rst", 32'(busy), 32'd1);
        dc  = done_cnt;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_eq("rst_outputs",
                 {26'd0, ps2_clk_oe, ps2_dat_oe, busy, done, ack_err, timeout}, 32'd0);
        dev_clk_low = 1'b0;
        repeat (30) @(negedge clk);
        check_eq("rst_no_done", 32'(done_cnt), 32'(dc));
        do_send(8'hF4, 1'b1, 1'b0);

        for (int r = 0; r < 6; r++) begin
            half = int'($urandom_range(8, 20));
            do_send(8'($urandom), ($urandom_range(0, 3) != 0), 1'b0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got no end of test, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
